// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) types, bit layout and encode function; the 7-bit decoder uses the same layout.
package hamming_pkg;

    typedef logic [6:0] codeword_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

    // Parity at codeword positions 1,2,4 (one-based), data in the remaining slots.
    localparam int P0_POS = 0;
    localparam int P1_POS = 1;
    localparam int D3_POS = 2;
    localparam int P2_POS = 3;
    localparam int D2_POS = 4;
    localparam int D1_POS = 5;
    localparam int D0_POS = 6;

    localparam logic [2:0] LAST_BIT = 3'd6;

    function automatic codeword_t hamming74_encode(input logic [3:0] d);
        codeword_t e;
        e         = '0;
        e[D3_POS] = d[3];
        e[D2_POS] = d[2];
        e[D1_POS] = d[1];
        e[D0_POS] = d[0];
        e[P0_POS] = d[3] ^ d[2] ^ d[0];
        e[P1_POS] = d[3] ^ d[1] ^ d[0];
        e[P2_POS] = d[2] ^ d[1] ^ d[0];
        return e;
    endfunction

endpackage

// File: rtl/hamming74_encoder_tx.sv
// Hamming(7,4) encoder + LSB-first serialiser; codeword and first bit one cycle after accept, 7+GAP_CYCLES cycles/frame.
// Bits advance only on ser_ready; HAMMING_ERR_INJECT_EN adds inj_en/inj_pos to flip one codeword bit on accept.
module hamming74_encoder_tx
    import hamming_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic [6:0] code_word,
    output logic       code_valid,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       ser_sof,
    input  logic       ser_ready,
    output logic       busy
`ifdef HAMMING_ERR_INJECT_EN
    ,
    input  logic       inj_en,
    input  logic [2:0] inj_pos
`endif
);

    localparam int GW         = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [GW-1:0] GAP_LAST = GAP_LAST_I[GW-1:0];

    tx_state_t   state_q;
    codeword_t   shreg_q;
    codeword_t   code_word_q;
    logic        code_valid_q;
    logic [2:0]  cnt_q;
    logic [GW-1:0] gap_q;

    codeword_t   flip;
    codeword_t   cw_d;
    logic        last_bit;
    logic        accept;

`ifdef HAMMING_ERR_INJECT_EN
    // inj_pos==7 shifts the one-hot out of the 7-bit window, giving no flip.
    assign flip = inj_en ? codeword_t'(8'd1 << inj_pos) : '0;
`else
    assign flip = '0;
`endif

    assign cw_d     = hamming74_encode(in_data) ^ flip;
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_BIT) && ser_ready;
    assign in_ready = (state_q == IDLE) || ((GAP_CYCLES == 0) && last_bit);
    assign accept   = in_valid && in_ready;

    assign ser_valid  = (state_q == SHIFT);
    assign ser_out    = shreg_q[0];
    assign ser_sof    = (state_q == SHIFT) && (cnt_q == 3'd0);
    assign busy       = (state_q != IDLE);
    assign code_word  = code_word_q;
    assign code_valid = code_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            code_word_q  <= '0;
            code_valid_q <= 1'b0;
            cnt_q        <= '0;
            gap_q        <= '0;
        end else begin
            code_valid_q <= accept;
            if (accept) begin
                code_word_q <= cw_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_q <= cw_d;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_ready) begin
                        if (cnt_q == LAST_BIT) begin
                            cnt_q <= '0;
                            if (accept) begin
                                shreg_q <= cw_d;
                            end else begin
                                shreg_q <= shreg_q >> 1;
                                gap_q   <= '0;
                                state_q <= (GAP_CYCLES == 0) ? IDLE : GAP;
                            end
                        end else begin
                            shreg_q <= shreg_q >> 1;
                            cnt_q   <= cnt_q + 3'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming74_encoder_tx.sv
// Bench for hamming74_encoder_tx: GAP_CYCLES=0 and GAP_CYCLES=3 instances share stimulus, each tracked by a frame model.
// Injection vectors are exercised only when HAMMING_ERR_INJECT_EN is defined.
module tb_hamming74_encoder_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       ser_ready;

    logic       in_ready_w   [2];
    logic [6:0] code_word_w  [2];
    logic       code_valid_w [2];
    logic       ser_out_w    [2];
    logic       ser_valid_w  [2];
    logic       ser_sof_w    [2];
    logic       busy_w       [2];

`ifdef HAMMING_ERR_INJECT_EN
    logic       inj_en;
    logic [2:0] inj_pos;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hamming74_encoder_tx #(.GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data),
        .code_word(code_word_w[0]), .code_valid(code_valid_w[0]), .ser_out(ser_out_w[0]),
        .ser_valid(ser_valid_w[0]), .ser_sof(ser_sof_w[0]), .ser_ready(ser_ready), .busy(busy_w[0])
`ifdef HAMMING_ERR_INJECT_EN
        , .inj_en(inj_en), .inj_pos(inj_pos)
`endif
    );

    hamming74_encoder_tx #(.GAP_CYCLES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data),
        .code_word(code_word_w[1]), .code_valid(code_valid_w[1]), .ser_out(ser_out_w[1]),
        .ser_valid(ser_valid_w[1]), .ser_sof(ser_sof_w[1]), .ser_ready(ser_ready), .busy(busy_w[1])
`ifdef HAMMING_ERR_INJECT_EN
        , .inj_en(inj_en), .inj_pos(inj_pos)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Codeword straight from the layout equations.
    function automatic logic [6:0] ref_enc(input logic [3:0] d);
        return {d[0], d[1], d[2], ^(d & 4'b0111), d[3], ^(d & 4'b1011), ^(d & 4'b1101)};
    endfunction

`ifdef HAMMING_ERR_INJECT_EN
    function automatic logic [2:0] syndrome(input logic [6:0] e);
        return {e[3] ^ e[4] ^ e[5] ^ e[6], e[1] ^ e[2] ^ e[5] ^ e[6], e[0] ^ e[2] ^ e[4] ^ e[6]};
    endfunction
`endif

    // Model: bits of the frame still owed, how many, and the last accepted codeword.
    logic [6:0] rem    [2];
    int         left   [2];
    logic [6:0] cw_e   [2];
    logic       cv_e   [2];
    logic [6:0] load;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk($sformatf("d%0d_rst_ser_valid", k), ser_valid_w[k], 1'b0);
                chk($sformatf("d%0d_rst_ser_sof", k), ser_sof_w[k], 1'b0);
                chk($sformatf("d%0d_rst_ser_out", k), ser_out_w[k], 1'b0);
                chk($sformatf("d%0d_rst_code_word", k), code_word_w[k], 7'h00);
                chk($sformatf("d%0d_rst_code_valid", k), code_valid_w[k], 1'b0);
                chk($sformatf("d%0d_rst_busy", k), busy_w[k], 1'b0);
                chk($sformatf("d%0d_rst_in_ready", k), in_ready_w[k], 1'b1);
                rem[k] = '0; left[k] = 0; cw_e[k] = '0; cv_e[k] = 1'b0;
            end else begin
                chk($sformatf("d%0d_ser_valid", k), ser_valid_w[k], left[k] != 0);
                chk($sformatf("d%0d_code_valid", k), code_valid_w[k], cv_e[k]);
                chk($sformatf("d%0d_code_word", k), code_word_w[k], cw_e[k]);
                if (left[k] != 0) begin
                    chk($sformatf("d%0d_ser_out", k), ser_out_w[k], rem[k][0]);
                    chk($sformatf("d%0d_ser_sof", k), ser_sof_w[k], left[k] == 7);
                    chk($sformatf("d%0d_busy", k), busy_w[k], 1'b1);
                    chk($sformatf("d%0d_in_ready", k), in_ready_w[k],
                        (left[k] == 1) && ser_ready && (k == 0));
                end else begin
                    chk($sformatf("d%0d_ser_sof_idle", k), ser_sof_w[k], 1'b0);
                end
                if (left[k] != 0 && ser_ready) begin
                    rem[k]  = rem[k] >> 1;
                    left[k] = left[k] - 1;
                end
                if (in_valid && in_ready_w[k]) begin
                    load = ref_enc(in_data);
`ifdef HAMMING_ERR_INJECT_EN
                    if (inj_en && inj_pos != 3'd7) load[inj_pos] = ~load[inj_pos];
`endif
                    rem[k] = load; left[k] = 7; cw_e[k] = load; cv_e[k] = 1'b1;
                end else begin
                    cv_e[k] = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk);
            #1;
            if (!busy_w[0] && !busy_w[1]) done = 1'b1;
        end
        chk("idle_timeout", done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [6:0] bits;
    logic [6:0] got_cw [3];
    logic [3:0] v2 [3];
    logic [31:0] pat;
    logic       acc, hit;
    int n, nsof, ncw, run, maxrun, irp, idx, seen, gapc, sv0;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; ser_ready = 1'b1;
`ifdef HAMMING_ERR_INJECT_EN
        inj_en = 1'b0; inj_pos = 3'd7;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single frame, d=1011
        @(posedge clk); #1 in_data = 4'b1011; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        bits = '0; nsof = 0; n = 0;
        for (int c = 0; c < 20 && n < 7; c++) begin
            @(negedge clk);
            if (ser_valid_w[0]) begin
                if (n == 0) chk("t1_first_sof", ser_sof_w[0], 1'b1);
                bits[n] = ser_out_w[0];
                nsof += int'(ser_sof_w[0]);
                n++;
            end
        end
        chk("t1_nbits", n, 7);
        chk("t1_bits", bits, 7'h66);
        chk("t1_code_word", code_word_w[0], 7'h66);
        chk("t1_nsof", nsof, 1);
        wait_idle();

        // Back-to-back 0,F,1 on the zero-gap instance
        v2[0] = 4'h0; v2[1] = 4'hF; v2[2] = 4'h1;
        idx = 0; ncw = 0; run = 0; maxrun = 0; irp = 0;
        in_data = v2[0]; in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (code_valid_w[0] && ncw < 3) begin got_cw[ncw] = code_word_w[0]; ncw++; end
            if (ser_valid_w[0]) run++; else run = 0;
            if (run > maxrun) maxrun = run;
            if (in_ready_w[0] && busy_w[0]) irp++;
            acc = in_valid && in_ready_w[0];
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx >= 3) in_valid = 1'b0; else in_data = v2[idx];
            end
        end
        chk("t2_accepts", idx, 3);
        chk("t2_ncw", ncw, 3);
        chk("t2_cw0", got_cw[0], 7'h00);
        chk("t2_cw1", got_cw[1], 7'h7F);
        chk("t2_cw2", got_cw[2], 7'h4B);
        chk("t2_contig_valid", maxrun, 21);
        chk("t2_in_ready_pulses", irp, 3);
        wait_idle();

        // Backpressure, d=0110
        pat = 32'b1011_0010_1110_0101_1101_0011_0110_1001;
        in_data = 4'h6; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        n = 0; bits = '0;
        for (int c = 0; c < 80 && n < 7; c++) begin
            @(negedge clk);
            if (ser_valid_w[0] && ser_ready) begin bits[n] = ser_out_w[0]; n++; end
            @(posedge clk); #1 ser_ready = pat[c % 32];
        end
        ser_ready = 1'b1;
        chk("t3_nbits", n, 7);
        chk("t3_bits", bits, 7'h33);
        wait_idle();

        // Gap between frames on the GAP_CYCLES=3 instance
        in_data = 4'hA; in_valid = 1'b1;
        seen = 0; gapc = 0; sv0 = 0;
        for (int c = 0; c < 60 && seen < 2; c++) begin
            @(negedge clk);
            if (ser_sof_w[1]) seen++;
            else if (seen == 1) begin
                if (!ser_valid_w[1] && !in_ready_w[1]) gapc++;
                if (!ser_valid_w[1]) sv0++;
            end
        end
        @(posedge clk); #1 in_valid = 1'b0;
        chk("t4_frames", seen, 2);
        chk("t4_gap_cycles", gapc, 3);
        chk("t4_invalid_cycles", sv0, 4);
        wait_idle();

        // Asynchronous reset at bit 3
        in_data = 4'hD; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        n = 0; hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (ser_valid_w[0]) begin
                if (n == 3) hit = 1'b1; else n++;
            end
        end
        chk("t5_reached_bit3", hit, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t5_d%0d_async_ser_valid", k), ser_valid_w[k], 1'b0);
            chk($sformatf("t5_d%0d_async_busy", k), busy_w[k], 1'b0);
            chk($sformatf("t5_d%0d_async_code_word", k), code_word_w[k], 7'h00);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1 in_data = 4'h8; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t5_restart_valid", ser_valid_w[0], 1'b1);
        chk("t5_restart_sof", ser_sof_w[0], 1'b1);
        chk("t5_restart_e0", ser_out_w[0], 1'b1);
        chk("t5_restart_cw", code_word_w[0], 7'h07);
        wait_idle();

`ifdef HAMMING_ERR_INJECT_EN
        inj_en = 1'b1; inj_pos = 3'd4; in_data = 4'b1011; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t6_inj4_cw", code_word_w[0], 7'h76);
        chk("t6_inj4_syndrome", syndrome(code_word_w[0]), 3'b101);
        wait_idle();
        inj_pos = 3'd7; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t6_inj7_cw", code_word_w[0], 7'h66);
        chk("t6_inj7_syndrome", syndrome(code_word_w[0]), 3'b000);
        wait_idle();
        inj_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
